// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response and the ID-side valid/ready head.
// master = fetch_queue, slave = memory + ID stage.
interface fetch_queue_if #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
);
    logic [DATA_W-1:0]  imem_addr;
    logic               imem_ren;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [DATA_W-1:0]  id_pc;
    logic [DATA_W-1:0]  id_pc_plus4;

    modport master (
        output imem_addr, imem_ren,
        input  imem_rdata,
        output id_valid,
        input  id_ready,
        output id_instr, id_pc, id_pc_plus4
    );

    modport slave (
        input  imem_addr, imem_ren,
        output imem_rdata,
        input  id_valid,
        output id_ready,
        input  id_instr, id_pc, id_pc_plus4
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetches and buffers responses in a DEPTH-entry queue.
// Optional macro FQ_BYPASS_EN: an empty queue forwards the arriving response straight to ID.
module fetch_queue #(
    parameter int                DATA_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    fetch_queue_if.master     bus,
    output logic [CNT_W-1:0]  fq_count
);
    localparam int                 PTR_W = $clog2(DEPTH);
    localparam logic [INSTR_W-1:0] NOP   = INSTR_W'(32'h0000_0013);

    logic [INSTR_W-1:0] instr_mem_r [DEPTH];
    logic [DATA_W-1:0]  pc_mem_r    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               inflight_r;
    logic [DATA_W-1:0]  tag_pc_r;
    logic [DATA_W-1:0]  fetch_pc_r;

    logic               push_s;
    logic               pop_s;
    logic               bypass_s;
    logic               valid_s;
    logic               issue_s;
    logic               write_s;
    logic               read_s;
    logic [CNT_W:0]     occ_s;
    logic [INSTR_W-1:0] instr_s;
    logic [DATA_W-1:0]  pc_s;

    // Handshake, issue credit and head selection
    always_comb begin
        push_s = inflight_r & ~redirect;
`ifdef FQ_BYPASS_EN
        bypass_s = (count_r == CNT_W'(0)) & push_s;
`else
        bypass_s = 1'b0;
`endif
        valid_s = ((count_r != CNT_W'(0)) | bypass_s) & ~redirect;
        pop_s   = valid_s & bus.id_ready & enable;
        // Pop is credited in the same cycle so a full stream never starves at DEPTH>=2
        occ_s   = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        issue_s = enable & ~redirect & (occ_s < (CNT_W + 1)'(DEPTH));
        write_s = push_s & ~(bypass_s & pop_s);
        read_s  = pop_s & ~bypass_s;
        if (!valid_s) begin
            instr_s = NOP;
            pc_s    = DATA_W'(0);
        end else if (bypass_s) begin
            instr_s = bus.imem_rdata;
            pc_s    = tag_pc_r;
        end else begin
            instr_s = instr_mem_r[rd_ptr_r];
            pc_s    = pc_mem_r[rd_ptr_r];
        end
    end

    // Fetch PC, in-flight tracking, pointers and occupancy
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fetch_pc_r <= RESET_PC;
            tag_pc_r   <= DATA_W'(0);
            inflight_r <= 1'b0;
            rd_ptr_r   <= PTR_W'(0);
            wr_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
            inflight_r <= 1'b0;
            rd_ptr_r   <= PTR_W'(0);
            wr_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                tag_pc_r   <= fetch_pc_r;
                fetch_pc_r <= fetch_pc_r + DATA_W'(4);
            end
            if (write_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (read_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({write_s, read_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are meaningless outside the valid window so no reset
    always_ff @(posedge clk) begin
        if (write_s) begin
            instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
            pc_mem_r[wr_ptr_r]    <= tag_pc_r;
        end
    end

    assign bus.imem_addr   = fetch_pc_r;
    assign bus.imem_ren    = issue_s;
    assign bus.id_valid    = valid_s;
    assign bus.id_instr    = instr_s;
    assign bus.id_pc       = pc_s;
    assign bus.id_pc_plus4 = pc_s + DATA_W'(4);
    assign fq_count        = count_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus reset and latency sequences.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic [2:0]  fq_count;

    int n_vec  = 0;
    int n_fail = 0;

    fetch_queue_if #(.DATA_W(64), .INSTR_W(32)) bus ();

    fetch_queue #(.DATA_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'd0)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .fq_count    (fq_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hC000_0000 ^ a[31:0];
    endfunction

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        if (bus.imem_ren) bus.imem_rdata <= instr_of(bus.imem_addr);
    end

    typedef struct {
        logic        en;
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic        ren;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic redir, input logic [63:0] rpc,
                                input logic rdy, input logic ren, input logic [63:0] addr,
                                input logic valid, input logic [63:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.en = en; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.ren = ren; v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic [31:0] exp_instr;
        @(posedge clk);
        #1;
        enable = v.en; redirect = v.redir; redirect_pc = v.rpc; bus.id_ready = v.rdy;
        @(negedge clk);
        exp_instr = v.valid ? instr_of(v.pc) : NOP;
        n_vec++;
        if (bus.imem_ren !== v.ren || bus.imem_addr !== v.addr || bus.id_valid !== v.valid ||
            bus.id_pc !== v.pc || bus.id_pc_plus4 !== v.pc + 64'd4 ||
            bus.id_instr !== exp_instr || fq_count !== v.cnt) begin
            n_fail++;
            $display("FAIL vec%0d: got ren=%0b addr=%0h valid=%0b pc=%0h pc4=%0h instr=%0h cnt=%0d expected ren=%0b addr=%0h valid=%0b pc=%0h pc4=%0h instr=%0h cnt=%0d",
                     idx, bus.imem_ren, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_pc_plus4,
                     bus.id_instr, fq_count, v.ren, v.addr, v.valid, v.pc, v.pc + 64'd4,
                     exp_instr, v.cnt);
        end
    endtask

    initial begin
        int lat;
        bus.id_ready = 1'b0;

        // Stream, stall to full, release, redirects, enable low
        add(1,0,0,1, 1,64'd0,  0,64'd0, 0);
        add(1,0,0,1, 1,64'd4,  0,64'd0, 0);
        add(1,0,0,1, 1,64'd8,  1,64'd0, 1);
        add(1,0,0,1, 1,64'd12, 1,64'd4, 1);
        add(1,0,0,1, 1,64'd16, 1,64'd8, 1);
        add(1,0,0,0, 1,64'd20, 1,64'd12,1);
        add(1,0,0,0, 1,64'd24, 1,64'd12,2);
        add(1,0,0,0, 0,64'd28, 1,64'd12,3);
        for (int i = 0; i < 5; i++) add(1,0,0,0, 0,64'd28, 1,64'd12,4);
        add(1,0,0,1, 1,64'd28, 1,64'd12,4);
        add(1,0,0,1, 1,64'd32, 1,64'd16,3);
        add(1,0,0,1, 1,64'd36, 1,64'd20,3);
        add(1,0,0,1, 1,64'd40, 1,64'd24,3);
        add(1,0,0,1, 1,64'd44, 1,64'd28,3);
        add(1,1,64'h100,0, 0,64'd48, 0,64'd0,3);
        add(1,0,0,1, 1,64'h100, 0,64'd0, 0);
        add(1,0,0,1, 1,64'h104, 0,64'd0, 0);
        add(1,0,0,1, 1,64'h108, 1,64'h100,1);
        add(1,1,64'h200,1, 0,64'h10C, 0,64'd0,1);
        add(1,1,64'h300,1, 0,64'h200, 0,64'd0,0);
        add(1,0,0,1, 1,64'h300, 0,64'd0, 0);
        add(1,0,0,1, 1,64'h304, 0,64'd0, 0);
        add(1,0,0,1, 1,64'h308, 1,64'h300,1);
        add(0,0,0,1, 0,64'h30C, 1,64'h304,1);
        add(0,0,0,1, 0,64'h30C, 1,64'h304,2);
        add(1,0,0,1, 1,64'h30C, 1,64'h304,2);
        add(1,0,0,1, 1,64'h310, 1,64'h308,1);
        add(1,0,0,1, 1,64'h314, 1,64'h30C,1);

        // Reset state
        #12;
        chk("rst_valid", {63'd0, bus.id_valid}, 64'd0);
        chk("rst_instr", {32'd0, bus.id_instr}, {32'd0, NOP});
        chk("rst_count", {61'd0, fq_count}, 64'd0);
        chk("rst_addr",  bus.imem_addr, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;

`ifndef FQ_BYPASS_EN
        foreach (vecs[i]) apply_vec(i, vecs[i]);
`endif

        // Mid-stream async reset with three queued entries
        @(posedge clk); #1;
        enable = 1'b1; redirect = 1'b0; bus.id_ready = 1'b0;
        for (int i = 0; i < 20 && fq_count != 3'd3; i++) @(negedge clk);
        chk("fill3", {61'd0, fq_count}, 64'd3);
        arst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, bus.id_valid}, 64'd0);
        chk("arst_count", {61'd0, fq_count}, 64'd0);
        chk("arst_addr",  bus.imem_addr, 64'd0);
        chk("arst_pc",    bus.id_pc, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        bus.id_ready = 1'b1;
        chk("resume_addr", bus.imem_addr, 64'd0);
        chk("resume_ren",  {63'd0, bus.imem_ren}, 64'd1);
        for (int i = 0; i < 10 && !bus.id_valid; i++) @(negedge clk);
        chk("resume_valid", {63'd0, bus.id_valid}, 64'd1);
        chk("resume_pc",    bus.id_pc, 64'd0);
        chk("resume_instr", {32'd0, bus.id_instr}, {32'd0, instr_of(64'd0)});

        // Issue-to-ID latency from an empty queue
        enable = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        enable = 1'b1; bus.id_ready = 1'b1;
        @(negedge clk);
        chk("lat_issue", {63'd0, bus.imem_ren}, 64'd1);
        lat = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.id_valid) lat = i;
        end
`ifdef FQ_BYPASS_EN
        chk("latency", 64'(lat), 64'd1);
        chk("bypass_count", {61'd0, fq_count}, 64'd0);
`else
        chk("latency", 64'(lat), 64'd2);
`endif
        chk("lat_pc", bus.id_pc, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
